// File: rtl/uart_rx_bank_loader.sv
// Framed UART write loader: parses opcode/bank/addr/len headers, assembles
// little-endian words and pulses a one-hot bank write per word.
module uart_rx_bank_loader #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned NUM_BANKS     = 2,
  parameter int unsigned MEMORY_DEPTH  = 1024,
  parameter logic [7:0]  WRITE_OPCODE  = 8'h57,
  parameter int unsigned TIMEOUT_BYTES = 16,
  localparam int unsigned ADDR_W       = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [NUM_BANKS-1:0]  we,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_code,
  output logic                  busy,
  output logic                  write_done,
  output logic                  err_bank,
  output logic                  err_len,
  output logic                  err_timeout
);
  localparam int unsigned WORD_BYTES = (DATA_WIDTH + 7) / 8;
  // Byte time is rounded to the nearest clock.
  localparam longint unsigned BYTE_CLKS = (64'd10 * CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
  localparam longint unsigned TMO_LIMIT = TIMEOUT_BYTES * BYTE_CLKS;
  localparam int TMO_W  = $clog2(TMO_LIMIT + 64'd1);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [8:0] NB9 = 9'(NUM_BANKS);

  typedef enum logic [2:0] {
    S_IDLE, S_BANK, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA
  } state_t;

  state_t                  state_q, state_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [BANK_W-1:0]       bank_q, bank_d;
  logic [7:0]              lo_q, lo_d;
  logic [ADDR_W-1:0]       cur_q, cur_d;
  logic [15:0]             rem_q, rem_d;
  logic [BC_W-1:0]         bcnt_q, bcnt_d;
  logic [8*WORD_BYTES-1:0] acc_q, acc_d;
  logic                    pend_q, pend_d;
  logic [NUM_BANKS-1:0]    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [7:0]              cmd_code_q, cmd_code_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    eb_q, eb_d, el_q, el_d, et_q, et_d;

  logic [8*WORD_BYTES-1:0] word;
  logic [15:0]             n16;
  logic [16:0]             end17;

  always_comb begin
    state_d = state_q;  tmo_d = tmo_q;     bank_d = bank_q;   lo_d = lo_q;
    cur_d = cur_q;      rem_d = rem_q;     bcnt_d = bcnt_q;   acc_d = acc_q;
    pend_d = 1'b0;      we_d = '0;         addr_d = addr_q;   wdata_d = wdata_q;
    cmd_valid_d = 1'b0; cmd_code_d = cmd_code_q;
    done_d = pend_q;    eb_d = 1'b0;       el_d = 1'b0;       et_d = 1'b0;
    word = acc_q;
    n16 = {rx_data, lo_q};
    end17 = 17'(cur_q) + 17'(n16);

    // Inter-byte watchdog; a byte arriving on the expiry cycle wins.
    if (state_q == S_IDLE || rx_valid) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TMO_LIMIT - 1)) begin
      tmo_d = '0;
      et_d = 1'b1;
      state_d = S_IDLE;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == WRITE_OPCODE) state_d = S_BANK;
          else begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = rx_data;
          end
        end
        S_BANK: begin
          if ({1'b0, rx_data} >= NB9) begin
            eb_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            bank_d = rx_data[BANK_W-1:0];
            state_d = S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          lo_d = rx_data;
          state_d = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          cur_d = ADDR_W'(n16);
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          lo_d = rx_data;
          state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          if (end17 > 17'(MEMORY_DEPTH)) begin
            el_d = 1'b1;
            state_d = S_IDLE;
          end else if (n16 == 16'd0) begin
            done_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            rem_d = n16;
            bcnt_d = '0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          word[8*bcnt_q +: 8] = rx_data;
          acc_d = word;
          if (bcnt_q == BC_W'(WORD_BYTES - 1)) begin
            bcnt_d = '0;
            we_d[bank_q] = 1'b1;
            addr_d = cur_q;
            wdata_d = word[DATA_WIDTH-1:0];
            cur_d = cur_q + ADDR_W'(1);
            rem_d = rem_q - 16'd1;
            // Last word: done pulse follows the write by one cycle.
            if (rem_q == 16'd1) begin
              pend_d = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE) || pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  tmo_q <= '0;       bank_q <= '0;    lo_q <= '0;
      cur_q <= '0;        rem_q <= '0;       bcnt_q <= '0;    acc_q <= '0;
      pend_q <= 1'b0;     we_q <= '0;        addr_q <= '0;    wdata_q <= '0;
      cmd_valid_q <= 1'b0; cmd_code_q <= '0; busy_q <= 1'b0;  done_q <= 1'b0;
      eb_q <= 1'b0;       el_q <= 1'b0;      et_q <= 1'b0;
    end else begin
      state_q <= state_d; tmo_q <= tmo_d;    bank_q <= bank_d; lo_q <= lo_d;
      cur_q <= cur_d;     rem_q <= rem_d;    bcnt_q <= bcnt_d; acc_q <= acc_d;
      pend_q <= pend_d;   we_q <= we_d;      addr_q <= addr_d; wdata_q <= wdata_d;
      cmd_valid_q <= cmd_valid_d; cmd_code_q <= cmd_code_d;
      busy_q <= busy_d;   done_q <= done_d;
      eb_q <= eb_d;       el_q <= el_d;      et_q <= et_d;
    end
  end

  assign we          = we_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign busy        = busy_q;
  assign write_done  = done_q;
  assign err_bank    = eb_q;
  assign err_len     = el_q;
  assign err_timeout = et_q;
endmodule

// File: tb/tb_uart_rx_bank_loader.sv
// Directed bench: per-cycle vector table for the frame parser, plus
// hand-written timeout and mid-frame reset sequences.
module tb_uart_rx_bank_loader;
  // 10*1_152_000/115200 = 100 clocks per byte exactly, so 1600-clock timeout.
  localparam int CLK_F = 1_152_000;
  localparam int BAUD  = 115200;
  localparam int TBYTES = 16;
  localparam int LIMIT = TBYTES * (10 * CLK_F / BAUD);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [1:0] we;
  logic [9:0] addr;
  logic [9:0] wdata;
  logic       cmd_valid, busy, write_done, err_bank, err_len, err_timeout;
  logic [7:0] cmd_code;

  always #5 clk = ~clk;

  uart_rx_bank_loader #(
    .CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD), .DATA_WIDTH(10), .NUM_BANKS(2),
    .MEMORY_DEPTH(1024), .WRITE_OPCODE(8'h57), .TIMEOUT_BYTES(TBYTES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .we(we), .addr(addr), .wdata(wdata), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .busy(busy), .write_done(write_done),
    .err_bank(err_bank), .err_len(err_len), .err_timeout(err_timeout)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [1:0] we;
    logic [9:0] addr;
    logic [9:0] wdata;
    logic       cv;
    logic [7:0] cc;
    logic [4:0] fl;  // {busy, write_done, err_bank, err_len, err_timeout}
  } vec_t;

  vec_t tbl[42];
  int tests = 0;
  int fails = 0;
  logic [21:0] wq[$];
  int n_tmo = 0;
  int n_done = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (we != 2'b00) wq.push_back({we, addr, wdata});
      if (err_timeout) n_tmo++;
      if (write_done) n_done++;
    end
  end

  function automatic vec_t mk(logic v, logic [7:0] d, logic [1:0] w, logic [9:0] a,
                              logic [9:0] wd, logic cv, logic [7:0] cc, logic [4:0] fl);
    vec_t r;
    r.v = v; r.d = d; r.we = w; r.addr = a; r.wdata = wd; r.cv = cv; r.cc = cc; r.fl = fl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] gfl;
    logic       bad;
    int         got_k;
    int         tmo0, done0;

    // Frame to bank 1, addr 0, 3 words
    tbl[0]  = mk(1, 8'h57, 2'b00, 10'h000, 10'h000, 0, 8'h00, 5'b10000);
    tbl[1]  = mk(1, 8'h01, 2'b00, 10'h000, 10'h000, 0, 8'h00, 5'b10000);
    tbl[2]  = mk(1, 8'h00, 2'b00, 10'h000, 10'h000, 0, 8'h00, 5'b10000);
    tbl[3]  = mk(1, 8'h00, 2'b00, 10'h000, 10'h000, 0, 8'h00, 5'b10000);
    tbl[4]  = mk(1, 8'h03, 2'b00, 10'h000, 10'h000, 0, 8'h00, 5'b10000);
    tbl[5]  = mk(1, 8'h00, 2'b00, 10'h000, 10'h000, 0, 8'h00, 5'b10000);
    tbl[6]  = mk(1, 8'h55, 2'b00, 10'h000, 10'h000, 0, 8'h00, 5'b10000);
    tbl[7]  = mk(1, 8'h01, 2'b10, 10'h000, 10'h155, 0, 8'h00, 5'b10000);
    tbl[8]  = mk(1, 8'hAA, 2'b00, 10'h000, 10'h155, 0, 8'h00, 5'b10000);
    tbl[9]  = mk(1, 8'h02, 2'b10, 10'h001, 10'h2AA, 0, 8'h00, 5'b10000);
    tbl[10] = mk(1, 8'hFF, 2'b00, 10'h001, 10'h2AA, 0, 8'h00, 5'b10000);
    tbl[11] = mk(1, 8'h03, 2'b10, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[12] = mk(0, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b01000);
    tbl[13] = mk(0, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b00000);
    // Non-write opcode
    tbl[14] = mk(1, 8'h52, 2'b00, 10'h002, 10'h3FF, 1, 8'h52, 5'b00000);
    tbl[15] = mk(0, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b00000);
    // Bad bank, then a command byte
    tbl[16] = mk(1, 8'h57, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[17] = mk(1, 8'h05, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b00100);
    tbl[18] = mk(1, 8'h52, 2'b00, 10'h002, 10'h3FF, 1, 8'h52, 5'b00000);
    // start 1022 + 3 words overruns depth 1024
    tbl[19] = mk(1, 8'h57, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[20] = mk(1, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[21] = mk(1, 8'hFE, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[22] = mk(1, 8'h03, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[23] = mk(1, 8'h03, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[24] = mk(1, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b00010);
    tbl[25] = mk(0, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b00000);
    // N=0 frame completes at once
    tbl[26] = mk(1, 8'h57, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[27] = mk(1, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[28] = mk(1, 8'h05, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[29] = mk(1, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[30] = mk(1, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[31] = mk(1, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b01000);
    // Last address of bank 0, exactly fits (1023 + 1 = 1024)
    tbl[32] = mk(1, 8'h57, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[33] = mk(1, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[34] = mk(1, 8'hFF, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[35] = mk(1, 8'h03, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[36] = mk(1, 8'h01, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[37] = mk(1, 8'h00, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[38] = mk(1, 8'h34, 2'b00, 10'h002, 10'h3FF, 0, 8'h00, 5'b10000);
    tbl[39] = mk(1, 8'h02, 2'b01, 10'h3FF, 10'h234, 0, 8'h00, 5'b10000);
    tbl[40] = mk(0, 8'h00, 2'b00, 10'h3FF, 10'h234, 0, 8'h00, 5'b01000);
    tbl[41] = mk(0, 8'h00, 2'b00, 10'h3FF, 10'h234, 0, 8'h00, 5'b00000);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {8'h00, we, addr, wdata, cmd_valid, busy, write_done, err_bank, err_len, err_timeout}, 32'h0);
    chk("reset_cmd_code", {24'h0, cmd_code}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      rx_valid = tbl[i].v;
      rx_data  = tbl[i].d;
      @(posedge clk);
      #1;
      gfl = {busy, write_done, err_bank, err_len, err_timeout};
      bad = (we !== tbl[i].we) || (addr !== tbl[i].addr) || (wdata !== tbl[i].wdata) ||
            (cmd_valid !== tbl[i].cv) || (gfl !== tbl[i].fl) ||
            (tbl[i].cv && (cmd_code !== tbl[i].cc));
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL vec%0d: got we=%b addr=%h wdata=%h cv=%b cc=%h fl=%b expected we=%b addr=%h wdata=%h cv=%b cc=%h fl=%b",
                 i, we, addr, wdata, cmd_valid, cmd_code, gfl,
                 tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].cv, tbl[i].cc, tbl[i].fl);
      end
    end
    rx_valid = 1'b0;

    // Timeout after one data byte
    wq.delete();
    send(8'h57); send(8'h00); send(8'h00); send(8'h00); send(8'h02); send(8'h00); send(8'hAA);
    got_k = 0;
    for (int k = 1; k <= LIMIT + 10; k++) begin
      @(posedge clk);
      #1;
      if (err_timeout) begin
        got_k = k;
        break;
      end
    end
    chk("timeout_latency", got_k, LIMIT);
    chk("timeout_busy", {31'h0, busy}, 32'h0);
    chk("timeout_no_we", wq.size(), 0);
    idle(1);
    chk("timeout_pulse_1cyc", {31'h0, err_timeout}, 32'h0);

    // Byte landing on the expiry cycle wins; frame then completes normally
    tmo0 = n_tmo;
    done0 = n_done;
    send(8'h57);
    idle(LIMIT - 1);
    send(8'h01); send(8'h10); send(8'h00); send(8'h01); send(8'h00); send(8'hAB); send(8'h01);
    idle(3);
    chk("expiry_byte_wins", n_tmo - tmo0, 0);
    chk("recover_nwrites", wq.size(), 1);
    if (wq.size() == 1) chk("recover_write", {10'h0, wq[0]}, {10'h0, 2'b10, 10'h010, 10'h1AB});
    chk("recover_done", n_done - done0, 1);

    // Mid-frame reset after two writes of an N=4 frame
    wq.delete();
    send(8'h57); send(8'h01); send(8'h20); send(8'h00); send(8'h04); send(8'h00);
    send(8'h11); send(8'h01); send(8'h22); send(8'h02); send(8'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {8'h00, we, addr, wdata, cmd_valid, busy, write_done, err_bank, err_len, err_timeout}, 32'h0);
    chk("midrst_cmd_code", {24'h0, cmd_code}, 32'h0);
    chk("midrst_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("midrst_w0", {10'h0, wq[0]}, {10'h0, 2'b10, 10'h020, 10'h111});
      chk("midrst_w1", {10'h0, wq[1]}, {10'h0, 2'b10, 10'h021, 10'h222});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    done0 = n_done;
    send(8'h57); send(8'h00); send(8'h05); send(8'h00); send(8'h02); send(8'h00);
    send(8'h23); send(8'h01); send(8'hFF); send(8'h00);
    idle(3);
    chk("postrst_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("postrst_w0", {10'h0, wq[0]}, {10'h0, 2'b01, 10'h005, 10'h123});
      chk("postrst_w1", {10'h0, wq[1]}, {10'h0, 2'b01, 10'h006, 10'h0FF});
    end
    chk("postrst_done", n_done - done0, 1);
    chk("postrst_busy", {31'h0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
